// File: rtl/hc4_mem_pkg.sv
// Shared types and constants for the nibble-RAM access sequencer.
package hc4_mem_pkg;

    localparam int RD_LAT_DEF = 2;  // default RAM read latency in cycles
    localparam int NIB_W      = 4;  // RAM data width (one nibble)

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RESP
    } state_e;

endpackage

// File: rtl/ram_access_seq.sv
// Bus-master sequencer in front of the 256-nibble RAM. Turns one- or
// two-nibble core requests into RAM address/write cycles and assembles
// the read data.
//
// Optional build macro RAM_WRAP_ERR_EN adds rsp_err, flagging a wide
// access that started at the top address and wrapped to address 0.
//
// Read timing: the low-nibble phase waits RD_LAT+1 cycles, giving the
// shared bus a turnaround cycle after the request is latched. The
// high-nibble phase waits exactly RD_LAT cycles, because its address is
// put on the bus at the same edge that samples the low nibble.
module ram_access_seq
    import hc4_mem_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF,  // legal 1..3
    parameter int AW     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_wide,
    input  logic [AW-1:0]    req_addr,
    input  logic [7:0]       req_wdata,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
`ifdef RAM_WRAP_ERR_EN
    output logic             rsp_err,
`endif
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [NIB_W-1:0] ram_wdata,
    output logic             ram_oe,
    input  logic [NIB_W-1:0] ram_rdata
);

    localparam logic [1:0] LAT_CNT = 2'(RD_LAT);

    state_e           state_q,   state_d;
    logic [AW-1:0]    addr_q,    addr_d;
    logic             wide_q,    wide_d;
    logic [NIB_W-1:0] whi_q,     whi_d;      // high write nibble, used in WR_HI
    logic [1:0]       cnt_q,     cnt_d;      // read latency counter
    logic [AW-1:0]    raddr_q,   raddr_d;
    logic             rwe_q,     rwe_d;
    logic [NIB_W-1:0] rwdata_q,  rwdata_d;
    logic [7:0]       rdata_q,   rdata_d;
`ifdef RAM_WRAP_ERR_EN
    logic             err_q,     err_d;
`endif

    // Next-state and RAM-cycle generation; RAM outputs are registered so
    // they are glitch-free for the whole cycle they apply to.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wide_d   = wide_q;
        whi_d    = whi_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        rwe_d    = 1'b0;
        rwdata_d = rwdata_q;
        rdata_d  = rdata_q;
`ifdef RAM_WRAP_ERR_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wide_d  = req_wide;
                    whi_d   = req_wdata[7:4];
                    raddr_d = req_addr;
                    cnt_d   = 2'd0;
`ifdef RAM_WRAP_ERR_EN
                    err_d   = req_wide && (req_addr == {AW{1'b1}});
`endif
                    if (req_we) begin
                        state_d  = WR_LO;
                        rwe_d    = 1'b1;
                        rwdata_d = req_wdata[3:0];
                    end else begin
                        state_d  = RD_LO;
                    end
                end
            end
            WR_LO: begin
                if (wide_q) begin
                    state_d  = WR_HI;
                    raddr_d  = addr_q + AW'(1);
                    rwdata_d = whi_q;
                    rwe_d    = 1'b1;
                end else begin
                    state_d  = RESP;
                end
            end
            WR_HI: state_d = RESP;
            RD_LO: begin
                if (cnt_q == LAT_CNT) begin
                    rdata_d = {4'b0, ram_rdata};
                    if (wide_q) begin
                        state_d = RD_HI;
                        raddr_d = addr_q + AW'(1);
                        cnt_d   = 2'd1;  // the address edge itself counts
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RD_HI: begin
                if (cnt_q == LAT_CNT) begin
                    rdata_d[7:4] = ram_rdata;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wide_q   <= 1'b0;
            whi_q    <= '0;
            cnt_q    <= 2'd0;
            raddr_q  <= '0;
            rwe_q    <= 1'b0;
            rwdata_q <= '0;
            rdata_q  <= '0;
`ifdef RAM_WRAP_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wide_q   <= wide_d;
            whi_q    <= whi_d;
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            rwe_q    <= rwe_d;
            rwdata_q <= rwdata_d;
            rdata_q  <= rdata_d;
`ifdef RAM_WRAP_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign ram_addr  = raddr_q;
    assign ram_we    = rwe_q;
    assign ram_oe    = rwe_q;
    assign ram_wdata = rwdata_q;
`ifdef RAM_WRAP_ERR_EN
    assign rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_ram_access_seq.sv
// Self-checking bench for ram_access_seq: directed vector table, held-request
// and mid-read reset sequences, then random traffic against a nibble-array
// reference model.
module tb_ram_access_seq;

    localparam int RD_LAT = 2;
    localparam int AW     = 8;
    localparam int PI     = (RD_LAT >= 2) ? RD_LAT - 2 : 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic         req_wide = 1'b0;
    logic [7:0]   req_addr = '0;
    logic [7:0]   req_wdata = '0;
    logic         rsp_valid;
    logic [7:0]   rsp_rdata;
`ifdef RAM_WRAP_ERR_EN
    logic         rsp_err;
`endif
    logic [7:0]   ram_addr;
    logic         ram_we;
    logic [3:0]   ram_wdata;
    logic         ram_oe;
    logic [3:0]   ram_rdata;

    always #5 clk = ~clk;

    ram_access_seq #(.RD_LAT(RD_LAT), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_wide(req_wide),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef RAM_WRAP_ERR_EN
        .rsp_err(rsp_err),
`endif
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_oe(ram_oe), .ram_rdata(ram_rdata)
    );

    // RAM model: data for an address appears RD_LAT edges after it is
    // presented and stays while the address is held.
    logic [3:0] mem [256];
    logic [7:0] apipe [3];
    logic       mem_clr = 1'b1;

    always @(posedge clk) begin
        apipe[0] <= ram_addr;
        apipe[1] <= apipe[0];
        apipe[2] <= apipe[1];
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 4'h0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = (RD_LAT == 1) ? mem[ram_addr] : mem[apipe[PI]];

    // Reference model state
    logic [3:0] ref_mem [256];
    logic [7:0] last_rd;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input bit we, input bit wide);
        if (we) return wide ? 3 : 2;
        return wide ? 2 * RD_LAT + 2 : RD_LAT + 2;
    endfunction

    // Present a request, wait (bounded) for ready, return just after the accept edge.
    task automatic accept(input string tag, input bit we, input bit wide,
                          input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        req_we = we; req_wide = wide; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 200) begin tick(); n++; end
        if (!req_ready) chk({tag, ".ready_timeout"}, 0, 1);
        tick();
        chk({tag, ".ready_drop"}, 32'(req_ready), 0);
    endtask

    // Watch the access until rsp_valid, checking latency, RAM write beats and response.
    task automatic observe(input string tag, input bit we, input bit wide,
                           input logic [7:0] a, input logic [7:0] d,
                           input int lat, input logic [7:0] rdata, input bit err);
        logic [7:0] ba [4];
        logic [3:0] bd [4];
        int nb = 0, noe = 0, k = 0;
        bit got = 1'b0;
        for (int i = 0; i < 4; i++) begin ba[i] = '0; bd[i] = '0; end
        while (k < 20) begin
            if (ram_we) begin
                if (nb < 4) begin ba[nb] = ram_addr; bd[nb] = ram_wdata; end
                nb++;
            end
            if (ram_oe) noe++;
            if (rsp_valid) begin got = 1'b1; break; end
            tick();
            k++;
        end
        chk({tag, ".lat"}, got ? k + 1 : 0, lat);
        chk({tag, ".rdata"}, 32'(rsp_rdata), 32'(rdata));
`ifdef RAM_WRAP_ERR_EN
        chk({tag, ".err"}, 32'(rsp_err), 32'(err));
`else
        if (err && !got) chk({tag, ".err_seen"}, 0, 1);
`endif
        chk({tag, ".we_beats"}, nb, we ? (wide ? 2 : 1) : 0);
        chk({tag, ".oe_beats"}, noe, we ? (wide ? 2 : 1) : 0);
        if (we) begin
            chk({tag, ".wa0"}, 32'(ba[0]), 32'(a));
            chk({tag, ".wd0"}, 32'(bd[0]), 32'(d[3:0]));
            if (wide) begin
                chk({tag, ".wa1"}, 32'(ba[1]), 32'(8'(a + 8'd1)));
                chk({tag, ".wd1"}, 32'(bd[1]), 32'(d[7:4]));
            end
        end
        tick();
        chk({tag, ".idle_ready"}, 32'(req_ready), 1);
        chk({tag, ".idle_rsp"},   32'(rsp_valid), 0);
        chk({tag, ".idle_we"},    32'(ram_we), 0);
        chk({tag, ".idle_addr"},  32'(ram_addr), 32'(wide ? 8'(a + 8'd1) : a));
    endtask

    task automatic model_update(input bit we, input bit wide,
                                input logic [7:0] a, input logic [7:0] d);
        if (we) begin
            ref_mem[a] = d[3:0];
            if (wide) ref_mem[8'(a + 8'd1)] = d[7:4];
        end
    endtask

    task automatic run_req(input string tag, input bit we, input bit wide,
                           input logic [7:0] a, input logic [7:0] d,
                           input int lat, input logic [7:0] rdata, input bit err);
        accept(tag, we, wide, a, d);
        req_valid = 1'b0;
        observe(tag, we, wide, a, d, lat, rdata, err);
        model_update(we, wide, a, d);
        if (!we) last_rd = rdata;
    endtask

    typedef struct {
        bit         we;
        bit         wide;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] rdata;
        bit         err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h10, 8'h0A, 2,            8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h20, 8'hC3, 3,            8'h00, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h20, 8'h00, 2*RD_LAT + 2, 8'hC3, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h21, 8'h00, RD_LAT + 2,   8'h0C, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h5E, 3,            8'h0C, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'hFF, 8'h00, 2*RD_LAT + 2, 8'h5E, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h00, RD_LAT + 2,   8'h05, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 8'hFF, 8'h07, 2,            8'h05, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'hFF, 8'h00, RD_LAT + 2,   8'h07, 1'b0};

        for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
        last_rd = 8'h00;

        // Reset with a write request pending: reset must win.
        req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b1;
        req_addr = 8'h33; req_wdata = 8'hFF;
        repeat (3) tick();
        chk("rst.ready", 32'(req_ready), 1);
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst.ram_addr", 32'(ram_addr), 0);
        chk("rst.ram_we", 32'(ram_we), 0);
        chk("rst.ram_oe", 32'(ram_oe), 0);
        chk("rst.ram_wdata", 32'(ram_wdata), 0);
`ifdef RAM_WRAP_ERR_EN
        chk("rst.rsp_err", 32'(rsp_err), 0);
`endif
        req_valid = 1'b0;
        rst_n = 1'b1;
        mem_clr = 1'b0;
        tick();
        chk("rst.post_ready", 32'(req_ready), 1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].wide, tbl[i].addr,
                    tbl[i].wdata, tbl[i].lat, tbl[i].rdata, tbl[i].err);
        end

        // Request held while busy is only taken once the sequencer is idle.
        accept("hold_w", 1'b1, 1'b1, 8'h40, 8'h96);
        req_we = 1'b0; req_wide = 1'b0; req_addr = 8'h41; req_wdata = 8'h00;
        observe("hold_w", 1'b1, 1'b1, 8'h40, 8'h96, 3, last_rd, 1'b0);
        model_update(1'b1, 1'b1, 8'h40, 8'h96);
        run_req("hold_r", 1'b0, 1'b0, 8'h41, 8'h00, RD_LAT + 2, 8'h09, 1'b0);

        // Reset during the high-nibble phase of a wide read.
        accept("rst_rd", 1'b0, 1'b1, 8'h20, 8'h00);
        req_valid = 1'b0;
        repeat (RD_LAT + 1) tick();
        chk("rst_rd.in_hi", 32'(ram_addr), 32'h21);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_rd.ready", 32'(req_ready), 1);
        chk("rst_rd.rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rd.ram_we", 32'(ram_we), 0);
        chk("rst_rd.rdata", 32'(rsp_rdata), 0);
        last_rd = 8'h00;
        begin
            int seen = 0;
            repeat (2 * RD_LAT + 3) begin
                tick();
                if (rsp_valid) seen++;
            end
            chk("rst_rd.no_rsp", seen, 0);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            bit         we   = 1'($urandom);
            bit         wide = 1'($urandom);
            logic [7:0] a    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            logic [7:0] d    = 8'($urandom);
            logic [7:0] er;
            er = we ? last_rd : {wide ? ref_mem[8'(a + 8'd1)] : 4'h0, ref_mem[a]};
            run_req($sformatf("rnd%0d", n), we, wide, a, d, exp_lat(we, wide), er,
                    wide && (a == 8'hFF));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_access_seq.md
Name: ram_access_seq

Overview:
- Bus-master sequencer directly upstream of the 256-nibble RAM.
- Accepts single-nibble or two-nibble (8-bit) read/write requests from the core over a valid/ready handshake.
- Generates the RAM address, write-enable and write-data/drive-enable, then returns assembled read data.
- Top level owns the tri-state: it drives the shared 4-bit data bus with ram_wdata when ram_oe=1 and feeds the bus back as ram_rdata.

Parameters:
- RD_LAT, 2, posedges from the cycle ram_addr is presented (read) to the cycle ram_rdata is sampled; legal 1..3.
- AW, 8, RAM address width (256 nibbles).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request (IDLE).
- req_we  in  1  1=write, 0=read.
- req_wide  in  1  1=two nibbles (addr, addr+1), 0=one nibble.
- req_addr  in  AW  start nibble address.
- req_wdata  in  8  write data; [3:0] to addr, [7:4] to addr+1.
- rsp_valid  out  1  one-cycle pulse: read data valid or write complete.
- rsp_rdata  out  8  read data; [7:4]=0 for narrow reads.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  4  nibble to drive on the data bus.
- ram_oe  out  1  top-level bus drive enable; equals ram_we.
- ram_rdata  in  4  data bus as seen by the sequencer.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_addr=0, ram_we=0, ram_oe=0, ram_wdata=0, latency counter=0. Reset mid-access abandons it with no rsp_valid; a write already presented may still land in the RAM.
- Accept: req_valid & req_ready at posedge latches addr/we/wide/wdata; req_ready drops the same edge.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RESP.
- Write sequence: WR_LO drives ram_addr=addr, ram_wdata=wdata[3:0], ram_we=ram_oe=1 for exactly one cycle.
  - If wide, WR_HI follows with addr+1 and wdata[7:4], also one cycle.
  - Then RESP.
  - Narrow write: rsp_valid 2 cycles after accept. Wide write: 3 cycles after accept.
- Read sequence: RD_LO holds ram_addr=addr, ram_we=0, and counts RD_LAT posedges, then samples ram_rdata into rsp_rdata[3:0].
  - Wide: RD_HI repeats with addr+1 into [7:4].
  - Then RESP.
  - Narrow read: rsp_valid RD_LAT+2 cycles after accept. Wide read: 2*RD_LAT+2 cycles after accept.
- RESP: rsp_valid=1 for one cycle; rsp_rdata holds until the next read completes. Next cycle: IDLE, req_ready=1. No back-to-back overlap.
- ram_we never asserts outside WR_LO/WR_HI. ram_addr holds its last value in IDLE.
- Address arithmetic is modulo 2^AW: addr+1 from 0xFF wraps to 0x00.
- req_valid while busy is ignored (req_ready=0). Requesters hold their request until accepted.
- Simultaneous reset and req_valid: reset wins; no accept.

Optional Feature:
- Macro: RAM_WRAP_ERR_EN.
- Defined: extra output port rsp_err (1 bit, reset 0), valid with rsp_valid, set when a wide access had addr=0xFF (wrap). The access still completes with wrapped addressing.
- Undefined: port absent; wrap is silent.

Decomposition:
- Package hc4_mem_pkg holds:
  - the state enum (IDLE..RESP);
  - the RD_LAT default constant;
  - the nibble width constant (4).
- Single module, no sub-module. The latency counter (2 bits) and nibble-half select are inline.

Test Plan:
- Reset then narrow write addr=0x10 wdata=0x0A -> one cycle with ram_addr=0x10, ram_we=ram_oe=1, ram_wdata=0xA; rsp_valid 2 cycles after accept.
- Wide write addr=0x20 wdata=0xC3, then wide read addr=0x20 with RAM model -> writes 0x3@0x20 and 0xC@0x21; read rsp_rdata=0xC3, rsp_valid 6 cycles after accept (RD_LAT=2).
- Narrow read addr=0x21 -> rsp_rdata=0x0C; req_valid held during busy not accepted until req_ready=1.
- Wide write addr=0xFF wdata=0x5E -> 0xE@0xFF, 0x5@0x00; with RAM_WRAP_ERR_EN, rsp_err=1; narrow access at 0xFF gives rsp_err=0.
- rst_n=0 asserted during RD_HI of wide read -> next cycle IDLE, req_ready=1, no rsp_valid, ram_we=0.
- RD_LAT=1 and RD_LAT=3 builds: narrow read latency 3 and 5 cycles respectively; data correct.
